// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, execute redirect, instruction-memory port and IF/ID outputs.
// The master modport is the fetch stage; slave is its environment (hazard unit, imem, decode).
interface fetch_stage_if;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, misalign_err, fetch_count
  );

  modport slave (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, applies execute redirects and loads the IF/ID register.
// A one-cycle BOOT state after reset release lets instruction memory settle before the first load.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fif
);

  typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc_d_r, pc_d_s;
  logic [31:0] pc_plus4_r, pc_plus4_s;
  logic        valid_r, valid_s;
  logic        err_r, err_s;
  logic [31:0] count_r, count_s;

  function automatic logic [31:0] inc4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Next-state, PC and IF/ID selection; redirect beats stall_f, flush beats stall_d.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    pc_d_s     = pc_d_r;
    pc_plus4_s = pc_plus4_r;
    valid_s    = valid_r;
    err_s      = err_r;
    count_s    = count_r;
    case (state_r)
      BOOT: begin
        state_s = RUN;
      end
      RUN: begin
        state_s = RUN;
        if (fif.pc_src_e) begin
          pc_s = {fif.pc_target_e[31:2], 2'b00};
          if (fif.pc_target_e[1:0] != 2'b00) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
        end else if (!fif.stall_f) begin
          pc_s = inc4(pc_r);
        end else begin
          pc_s = pc_r;
        end
        if (fif.flush_d) begin
          instr_s    = NOP_INSTR;
          pc_d_s     = 32'h0000_0000;
          pc_plus4_s = 32'h0000_0000;
          valid_s    = 1'b0;
        end else if (!fif.stall_d) begin
          instr_s    = fif.imem_rdata;
          pc_d_s     = pc_r;
          pc_plus4_s = inc4(pc_r);
          valid_s    = 1'b1;
          count_s    = count_r + 32'd1;
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // State and pipeline registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      pc_d_r     <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      count_r    <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      pc_d_r     <= pc_d_s;
      pc_plus4_r <= pc_plus4_s;
      valid_r    <= valid_s;
      err_r      <= err_s;
      count_r    <= count_s;
    end
  end

  assign fif.imem_addr    = pc_r;
  assign fif.instr_d      = instr_r;
  assign fif.pc_d         = pc_d_r;
  assign fif.pc_plus4_d   = pc_plus4_r;
  assign fif.valid_d      = valid_r;
  assign fif.misalign_err = err_r;
  assign fif.fetch_count  = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized hazard/redirect traffic
// compared against a rule-level reference model; a second instance covers PC wrap from 0xFFFF_FFFC.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic addr_mode = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_stage_if fif();
  fetch_stage_if fif2();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .fif(fif)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut2 (
    .clk(clk), .rst(rst), .fif(fif2)
  );

  always #5 clk = ~clk;

  // Instruction memory: address-as-data, or a scrambled word so instr_d differs from pc_d.
  assign fif.imem_rdata  = addr_mode ? fif.imem_addr
                         : ({fif.imem_addr[15:0], fif.imem_addr[31:16]} ^ 32'h1357_9BDF);
  assign fif2.imem_rdata = fif2.imem_addr;

  // Reference model state.
  logic        m_booted;
  logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_cnt;
  logic        m_valid, m_err;

  function automatic logic [31:0] mem_f(input logic [31:0] a, input logic mode);
    if (mode) return a;
    else      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = 32'h0000_0000;
    m_instr  = 32'h0000_0013;
    m_pcd    = 32'h0000_0000;
    m_p4     = 32'h0000_0000;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 32'h0000_0000;
  endtask

  task automatic compare_all();
    check_eq("imem_addr",    fif.imem_addr, m_pc);
    check_eq("instr_d",      fif.instr_d, m_instr);
    check_eq("pc_d",         fif.pc_d, m_pcd);
    check_eq("pc_plus4_d",   fif.pc_plus4_d, m_p4);
    check_eq("valid_d",      {31'd0, fif.valid_d}, {31'd0, m_valid});
    check_eq("misalign_err", {31'd0, fif.misalign_err}, {31'd0, m_err});
    check_eq("fetch_count",  fif.fetch_count, m_cnt);
  endtask

  // One clock: drive hazard inputs, let the edge happen, advance the model, compare, end at negedge.
  task automatic step(input logic sf, input logic sd, input logic fl,
                      input logic src, input logic [31:0] tgt);
    logic [31:0] pc_old;
    fif.stall_f     = sf;
    fif.stall_d     = sd;
    fif.flush_d     = fl;
    fif.pc_src_e    = src;
    fif.pc_target_e = tgt;
    @(posedge clk);
    pc_old = m_pc;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else begin
      if (src) begin
        m_pc = tgt & 32'hFFFF_FFFC;
        if (tgt % 32'd4 != 32'd0) m_err = 1'b1;
      end else if (!sf) begin
        m_pc = pc_old + 32'd4;
      end
      if (fl) begin
        m_instr = 32'h0000_0013; m_pcd = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
      end else if (!sd) begin
        m_instr = mem_f(pc_old, addr_mode);
        m_pcd   = pc_old;
        m_p4    = pc_old + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
    end
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    fif.stall_f = 1'b0; fif.stall_d = 1'b0; fif.flush_d = 1'b0;
    fif.pc_src_e = 1'b0; fif.pc_target_e = 32'd0;
    fif2.stall_f = 1'b0; fif2.stall_d = 1'b0; fif2.flush_d = 1'b0;
    fif2.pc_src_e = 1'b0; fif2.pc_target_e = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    check_eq("rst_instr_nop", fif.instr_d, 32'h0000_0013);
    check_eq("wrap_rst_pc", fif2.imem_addr, 32'hFFFF_FFFC);

    // Boot edge then three sequential loads.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("boot_pc_hold", fif.imem_addr, 32'h0000_0000);
    check_eq("boot_valid", {31'd0, fif.valid_d}, 32'd0);
    check_eq("wrap_boot_pc", fif2.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("wrap_second_addr", fif2.imem_addr, 32'h0000_0000);
    check_eq("wrap_pc_plus4", fif2.pc_plus4_d, 32'h0000_0000);
    check_eq("wrap_pc_d", fif2.pc_d, 32'hFFFF_FFFC);
    check_eq("first_valid", {31'd0, fif.valid_d}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("third_instr", fif.instr_d, 32'h0000_0008);
    check_eq("third_pc_plus4", fif.pc_plus4_d, 32'h0000_000C);
    check_eq("count_after_3", fif.fetch_count, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("pc_at_0x10", fif.imem_addr, 32'h0000_0010);

    // Two-cycle full stall, then resume with no skipped address.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("stall_pc", fif.imem_addr, 32'h0000_0010);
    check_eq("stall_count", fif.fetch_count, 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("resume_instr", fif.instr_d, 32'h0000_0010);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("pc_at_0x20", fif.imem_addr, 32'h0000_0020);

    // Redirect with flush, then the target is loaded.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    check_eq("redir_pc", fif.imem_addr, 32'h0000_0100);
    check_eq("redir_bubble", fif.instr_d, 32'h0000_0013);
    check_eq("redir_err_clear", {31'd0, fif.misalign_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("redir_pc_d", fif.pc_d, 32'h0000_0100);

    // Every control asserted at once.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check_eq("all_pc", fif.imem_addr, 32'h0000_0040);
    check_eq("all_valid", {31'd0, fif.valid_d}, 32'd0);
    check_eq("all_count", fif.fetch_count, 32'd9);

    // Misaligned redirect target; error is sticky.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
    check_eq("mis_pc", fif.imem_addr, 32'h0000_0100);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("mis_sticky", {31'd0, fif.misalign_err}, 32'd1);

    // Randomized hazard and redirect traffic against the model.
    addr_mode = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic        src, fl, sf, sd;
      logic [31:0] tgt;
      src = ($urandom_range(0, 99) < 10);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      fl  = src ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      step(sf, sd, fl, src, tgt);
    end

    // Asynchronous reset between edges, held across an edge, then restart.
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("restart_pc_d", fif.pc_d, 32'h0000_0000);
    check_eq("restart_count", fif.fetch_count, 32'd1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
